// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch path. Decode and the ROM model
// reuse the word/address widths, the reset PC and the halt word from here.
//   ADDR_W    : ROM address / PC width
//   DATA_W    : instruction word width
//   RESET_PC  : PC value after reset
//   HALT_WORD : word that stops fetching (also what unmapped ROM returns)
//   fetch_state_e : fetch FSM states
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  localparam logic [ADDR_W-1:0] RESET_PC  = 8'h00;
  localparam logic [DATA_W-1:0] HALT_WORD = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Small FIFO of {pc, word} pairs between the fetch FSM and decode.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   push, push_pc,
//   push_data             : write one entry (ignored while full unless popping)
//   pop                   : remove the head entry (ignored while empty)
//   flush                 : drop every entry; wins over push and pop
//   full, empty           : occupancy flags
//   head_pc, head_data    : oldest entry, stable until it is popped
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_pc,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W-1:0] head_pc,
  output logic [DATA_W-1:0] head_data
);

  import fetch_pkg::*;

  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QDEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic push_eff;
  logic pop_eff;

  logic [ADDR_W-1:0] pc_mem   [QDEPTH];
  logic [DATA_W-1:0] data_mem [QDEPTH];

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);

  // A push into a full queue is only legal when the head leaves this cycle.
  assign pop_eff  = pop & ~empty & ~flush;
  assign push_eff = push & ~flush & (~full | pop_eff);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop_eff) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      if (push_eff) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // One register pair per slot; each slot owns its own storage so the
  // head after reset reads as zero.
  generate
    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
      logic [ADDR_W-1:0] slot_pc_q;
      logic [DATA_W-1:0] slot_data_q;
      logic              slot_we;

      assign slot_we = push_eff && (wr_ptr_q == PTR_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          slot_pc_q   <= '0;
          slot_data_q <= '0;
        end else if (slot_we) begin
          slot_pc_q   <= push_pc;
          slot_data_q <= push_data;
        end
      end

      assign pc_mem[gi]   = slot_pc_q;
      assign data_mem[gi] = slot_data_q;
    end
  endgenerate

  assign head_pc   = pc_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch unit for a combinational instruction ROM. Owns the PC, drives the ROM
// address straight from it, and buffers fetched words for decode.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : leave IDLE and fetch from the current PC
//   rom_addr        : ROM address (the PC register)
//   rom_data        : ROM word for rom_addr, same cycle
//   redirect_valid,
//   redirect_pc     : branch/jump; flushes the queue and reloads the PC
//   instr_valid,
//   instr_ready     : handshake towards decode
//   instr_data,
//   instr_pc        : queue head word and the address it came from
//   halted          : FSM is in HALTED
//   busy            : FSM is in FETCH
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 16,
  parameter int                QDEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = 8'h00,
  parameter logic [DATA_W-1:0] HALT_WORD = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted,
  output logic              busy
);

  import fetch_pkg::*;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc_d;
  logic              halted_q;
  logic              busy_q;

  logic q_full;
  logic q_empty;
  logic q_pop;
  logic q_push;
  logic can_accept;
  logic is_halt_word;

  assign q_pop        = ~q_empty & instr_ready;
  assign can_accept   = (state_q == ST_FETCH) && (~q_full || q_pop);
  assign is_halt_word = (rom_data == HALT_WORD);
  assign pc_inc_d     = pc_q + ADDR_W'(1);

  // The ROM word goes straight into the queue; a redirect discards it.
  assign q_push = ~redirect_valid & can_accept & ~is_halt_word;

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_pc   (pc_q),
    .push_data (rom_data),
    .pop       (q_pop),
    .flush     (redirect_valid),
    .full      (q_full),
    .empty     (q_empty),
    .head_pc   (instr_pc),
    .head_data (instr_data)
  );

  // Single FSM block: state, PC and the registered status flags move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
    end else if (redirect_valid) begin
      state_q  <= ST_FETCH;
      pc_q     <= redirect_pc;
      halted_q <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FETCH;
            busy_q  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (can_accept) begin
            if (is_halt_word) begin
              // PC stays on the halt word so rom_addr shows where fetch stopped.
              state_q  <= ST_HALTED;
              halted_q <= 1'b1;
              busy_q   <= 1'b0;
            end else begin
              pc_q <= pc_inc_d;
            end
          end
        end
        ST_HALTED: begin
          // Only a redirect (handled above) restarts fetching.
        end
        default: begin
          state_q  <= ST_IDLE;
          halted_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr    = pc_q;
  assign instr_valid = ~q_empty;
  assign halted      = halted_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int QD = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr_data;
  logic [7:0]  instr_pc;
  logic        halted;
  logic        busy;

  logic [15:0] rom_mem [256];
  assign rom_data = rom_mem[rom_addr];

  instr_fetch #(
    .ADDR_W    (8),
    .DATA_W    (16),
    .QDEPTH    (QD),
    .RESET_PC  (8'h00),
    .HALT_WORD (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .halted         (halted),
    .busy           (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ---------------- ROM images ----------------
  task automatic rom_program();
    for (int i = 0; i < 256; i++) rom_mem[i] = (i < 16) ? 16'hC000 : 16'h0000;
  endtask

  task automatic rom_fill(input logic [15:0] w);
    for (int i = 0; i < 256; i++) rom_mem[i] = w;
  endtask

  task automatic rom_random();
    for (int i = 0; i < 256; i++)
      rom_mem[i] = ($urandom_range(0, 11) == 0) ? 16'h0000 : 16'($urandom_range(1, 16'hFFFF));
  endtask

  // ---------------- reset: ends at posedge + 1 ----------------
  task automatic do_reset();
    start = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- beat collection ----------------
  logic [7:0]  beat_pc[$];
  logic [15:0] beat_data[$];

  task automatic collect(input int ncyc);
    repeat (ncyc) begin
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        beat_pc.push_back(instr_pc);
        beat_data.push_back(instr_data);
        $display("beat pc=%h data=%h", instr_pc, instr_data);
      end
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
  } ent_t;

  ent_t       mq[$];
  int         m_st;   // 0 idle, 1 fetching, 2 halted
  logic [7:0] m_pc;

  task automatic model_reset();
    mq.delete();
    m_st = 0;
    m_pc = 8'h00;
  endtask

  task automatic model_check(input int cyc);
    chk($sformatf("rnd%0d valid", cyc), 32'(instr_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk($sformatf("rnd%0d pc", cyc), 32'(instr_pc), 32'(mq[0].pc));
      chk($sformatf("rnd%0d data", cyc), 32'(instr_data), 32'(mq[0].data));
    end
    chk($sformatf("rnd%0d halted", cyc), 32'(halted), 32'(m_st == 2));
    chk($sformatf("rnd%0d busy", cyc), 32'(busy), 32'(m_st == 1));
    chk($sformatf("rnd%0d addr", cyc), 32'(rom_addr), 32'(m_pc));
  endtask

  task automatic model_step();
    int   sz;
    bit   popv;
    logic [15:0] w;
    sz   = mq.size();
    popv = (sz > 0) && instr_ready;
    if (popv) void'(mq.pop_front());
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc;
      m_st = 1;
    end else begin
      case (m_st)
        0: if (start) m_st = 1;
        1: if (sz < QD || popv) begin
             w = rom_mem[m_pc];
             if (w == 16'h0000) m_st = 2;
             else begin
               mq.push_back('{pc: m_pc, data: w});
               m_pc = m_pc + 8'd1;
             end
           end
        default: ;
      endcase
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic       start;
    logic       redir;
    logic [7:0] rpc;
    logic       ready;
    logic       exp_valid;
    logic [7:0] exp_pc;
    logic       exp_busy;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    rst_n = 1'b0;
    start = 0; redirect_valid = 0; redirect_pc = 0; instr_ready = 0;
    rom_program();

    // Reset state (asynchronous, visible before any clock edge)
    #1;
    chk("rst valid", 32'(instr_valid), 32'd0);
    chk("rst data", 32'(instr_data), 32'd0);
    chk("rst pc", 32'(instr_pc), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst addr", 32'(rom_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: straight-line program to halt
    instr_ready = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    beat_pc.delete(); beat_data.delete();
    collect(30);
    chk("s1 beats", 32'(beat_pc.size()), 32'd16);
    for (int i = 0; i < 16 && i < beat_pc.size(); i++) begin
      chk($sformatf("s1 pc%0d", i), 32'(beat_pc[i]), 32'(i));
      chk($sformatf("s1 data%0d", i), 32'(beat_data[i]), 32'hC000);
    end
    chk("s1 halted", 32'(halted), 32'd1);
    chk("s1 busy", 32'(busy), 32'd0);
    chk("s1 addr", 32'(rom_addr), 32'h10);

    // Scenario 4: restart from HALTED
    redirect_valid = 1; redirect_pc = 8'h0E;
    @(posedge clk); #1;
    redirect_valid = 0;
    beat_pc.delete(); beat_data.delete();
    collect(10);
    chk("s4 beats", 32'(beat_pc.size()), 32'd2);
    if (beat_pc.size() >= 2) begin
      chk("s4 pc0", 32'(beat_pc[0]), 32'h0E);
      chk("s4 pc1", 32'(beat_pc[1]), 32'h0F);
    end
    chk("s4 halted", 32'(halted), 32'd1);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    chk("s4 start ignored halted", 32'(halted), 32'd1);
    chk("s4 start ignored busy", 32'(busy), 32'd0);
    chk("s4 start ignored valid", 32'(instr_valid), 32'd0);
    chk("s4 start ignored addr", 32'(rom_addr), 32'h10);

    // Scenario 5: PC wrap
    rom_fill(16'h1234);
    redirect_valid = 1; redirect_pc = 8'hFE;
    @(posedge clk); #1;
    redirect_valid = 0;
    beat_pc.delete(); beat_data.delete();
    collect(5);
    chk("s5 beats", 32'(beat_pc.size() >= 4), 32'd1);
    if (beat_pc.size() >= 4) begin
      chk("s5 pc0", 32'(beat_pc[0]), 32'hFE);
      chk("s5 pc1", 32'(beat_pc[1]), 32'hFF);
      chk("s5 pc2", 32'(beat_pc[2]), 32'h00);
      chk("s5 pc3", 32'(beat_pc[3]), 32'h01);
      chk("s5 data3", 32'(beat_data[3]), 32'h1234);
    end

    // Scenarios 2 and 3: backpressure, then redirect with a full queue
    vecs[0]  = '{1, 0, 8'h00, 0, 0, 8'h00, 1, 8'h00};
    vecs[1]  = '{0, 0, 8'h00, 0, 1, 8'h00, 1, 8'h01};
    vecs[2]  = '{0, 0, 8'h00, 0, 1, 8'h00, 1, 8'h02};
    vecs[3]  = '{0, 0, 8'h00, 0, 1, 8'h00, 1, 8'h02};
    vecs[4]  = '{0, 0, 8'h00, 0, 1, 8'h00, 1, 8'h02};
    vecs[5]  = '{0, 0, 8'h00, 0, 1, 8'h00, 1, 8'h02};
    vecs[6]  = '{0, 0, 8'h00, 1, 1, 8'h01, 1, 8'h03};
    vecs[7]  = '{0, 0, 8'h00, 1, 1, 8'h02, 1, 8'h04};
    vecs[8]  = '{0, 0, 8'h00, 1, 1, 8'h03, 1, 8'h05};
    vecs[9]  = '{0, 1, 8'h08, 0, 0, 8'h00, 1, 8'h08};
    vecs[10] = '{0, 0, 8'h00, 0, 1, 8'h08, 1, 8'h09};
    vecs[11] = '{0, 0, 8'h00, 0, 1, 8'h08, 1, 8'h0A};
    vecs[12] = '{0, 0, 8'h00, 1, 1, 8'h09, 1, 8'h0B};
    rom_program();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      start = vecs[i].start;
      redirect_valid = vecs[i].redir;
      redirect_pc = vecs[i].rpc;
      instr_ready = vecs[i].ready;
      @(posedge clk); #1;
      $display("vec %0d valid=%0b pc=%h addr=%h busy=%0b", i, instr_valid, instr_pc, rom_addr, busy);
      chk($sformatf("vec%0d valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d pc", i), 32'(instr_pc), 32'(vecs[i].exp_pc));
        chk($sformatf("vec%0d data", i), 32'(instr_data), 32'hC000);
      end
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d addr", i), 32'(rom_addr), 32'(vecs[i].exp_addr));
    end
    start = 0; redirect_valid = 0;

    // Scenario 6: reset mid-stream
    do_reset();
    instr_ready = 1;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("s6 valid", 32'(instr_valid), 32'd0);
    chk("s6 busy", 32'(busy), 32'd0);
    chk("s6 halted", 32'(halted), 32'd0);
    chk("s6 addr", 32'(rom_addr), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("s6 idle%0d valid", i), 32'(instr_valid), 32'd0);
      chk($sformatf("s6 idle%0d addr", i), 32'(rom_addr), 32'h00);
    end
    start = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    chk("s6 restart valid", 32'(instr_valid), 32'd1);
    chk("s6 restart pc", 32'(instr_pc), 32'h00);

    // Randomized run against the reference model
    rom_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 1500; c++) begin
      start          = ($urandom_range(0, 7) == 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = 8'($urandom_range(0, 255));
      instr_ready    = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      model_check(c);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
